// File: rtl/cordic_multimode_core.sv
// Iterative multi-mode CORDIC engine: circular, linear or hyperbolic coordinates,
// rotation or vectoring. The engine runs one iteration per clock. It reads the
// per-iteration angle constant from an external combinational table that is
// addressed by (tbl_coord, tbl_shift).
module cordic_multimode_core #(
    parameter int DATA_WIDTH  = 16,
    parameter int ITER        = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_x,
    input  logic [DATA_WIDTH-1:0]  in_y,
    input  logic [DATA_WIDTH-1:0]  in_z,
    input  logic [1:0]             in_coord,
    input  logic                   in_vec,
    output logic [1:0]             tbl_coord,
    output logic [SHIFT_WIDTH-1:0] tbl_shift,
    input  logic [DATA_WIDTH-1:0]  delta_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_x,
    output logic [DATA_WIDTH-1:0]  out_y,
    output logic [DATA_WIDTH-1:0]  out_z
);

    localparam int STEP_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        r_state;
    logic signed [DATA_WIDTH-1:0]  r_x;
    logic signed [DATA_WIDTH-1:0]  r_y;
    logic signed [DATA_WIDTH-1:0]  r_z;
    logic [1:0]                    r_coord;
    logic                          r_vec;
    logic [STEP_W-1:0]             r_step;
    logic [SHIFT_WIDTH-1:0]        r_shift;
    logic                          r_rep;     // current hyperbolic shift already repeated

    logic                          w_hyp;
    logic                          w_lin;
    logic                          w_d_pos;   // d = +1
    logic                          w_hold;    // hyperbolic shift is used a second time
    logic                          w_last;
    logic signed [DATA_WIDTH-1:0]  w_xs;
    logic signed [DATA_WIDTH-1:0]  w_ys;
    logic [DATA_WIDTH-1:0]         w_x_next;
    logic [DATA_WIDTH-1:0]         w_y_next;
    logic [DATA_WIDTH-1:0]         w_z_next;

    assign w_hyp  = (r_coord == 2'b10);
    assign w_lin  = (r_coord == 2'b01);
    assign w_last = (r_step == STEP_W'(ITER - 1));
    assign w_hold = w_hyp && !r_rep &&
                    ((r_shift == SHIFT_WIDTH'(4)) || (r_shift == SHIFT_WIDTH'(13)));

    // Direction and shifted operands; large shifts collapse to pure sign fill
    always_comb begin
        w_d_pos = r_vec ? r_y[DATA_WIDTH-1] : ~r_z[DATA_WIDTH-1];
        if (32'(r_shift) >= DATA_WIDTH) begin
            w_xs = {DATA_WIDTH{r_x[DATA_WIDTH-1]}};
            w_ys = {DATA_WIDTH{r_y[DATA_WIDTH-1]}};
        end else begin
            w_xs = r_x >>> r_shift;
            w_ys = r_y >>> r_shift;
        end
    end

    // One CORDIC micro-rotation; reserved coordinate code behaves as circular
    always_comb begin
        if (w_lin)
            w_x_next = r_x;
        else if (w_hyp)
            w_x_next = w_d_pos ? r_x + w_ys : r_x - w_ys;
        else
            w_x_next = w_d_pos ? r_x - w_ys : r_x + w_ys;
        w_y_next = w_d_pos ? r_y + w_xs : r_y - w_xs;
        w_z_next = w_d_pos ? r_z - delta_z : r_z + delta_z;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_coord <= '0;
            r_vec   <= 1'b0;
            r_step  <= '0;
            r_shift <= '0;
            r_rep   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_x;
                        r_y     <= in_y;
                        r_z     <= in_z;
                        r_coord <= in_coord;
                        r_vec   <= in_vec;
                        r_step  <= '0;
                        r_shift <= (in_coord == 2'b10) ? SHIFT_WIDTH'(1) : '0;
                        r_rep   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x    <= w_x_next;
                    r_y    <= w_y_next;
                    r_z    <= w_z_next;
                    r_step <= r_step + 1'b1;
                    if (w_hyp) begin
                        r_rep   <= w_hold;
                        r_shift <= w_hold ? r_shift : r_shift + 1'b1;
                    end else begin
                        r_shift <= SHIFT_WIDTH'(r_step + 1'b1);
                    end
                    if (w_last)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_DONE);
    assign out_x     = out_valid ? r_x : '0;
    assign out_y     = out_valid ? r_y : '0;
    assign out_z     = out_valid ? r_z : '0;
    assign tbl_coord = r_coord;
    assign tbl_shift = r_shift;

endmodule

// File: tb/tb_cordic_multimode_core.sv
// Randomized self-checking bench for cordic_multimode_core against a
// schedule-driven arithmetic reference model.
module tb_cordic_multimode_core;

    localparam int DW   = 16;
    localparam int ITER = 16;
    localparam int SW   = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x, in_y, in_z;
    logic [1:0]    in_coord;
    logic          in_vec;
    logic [1:0]    tbl_coord;
    logic [SW-1:0] tbl_shift;
    logic [DW-1:0] delta_z;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_x, out_y, out_z;

    logic [DW-1:0] tbl [4][32];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_ops    = 0;
    int            sh_q[$];
    int            co_q[$];

    cordic_multimode_core #(.DATA_WIDTH(DW), .ITER(ITER), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .in_coord(in_coord), .in_vec(in_vec),
        .tbl_coord(tbl_coord), .tbl_shift(tbl_shift), .delta_z(delta_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    always #5 clk = ~clk;

    assign delta_z = tbl[tbl_coord][tbl_shift];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] near(input logic [DW-1:0] v, input int tgt, input int tol);
        int sv;
        sv = int'($signed(v));
        return ((sv - tgt) <= tol && (tgt - sv) <= tol) ? 32'd1 : 32'd0;
    endfunction

    function automatic int wrap16(input int a);
        shortint t;
        t = shortint'(a);
        return int'(t);
    endfunction

    // Reference: build the shift schedule from the coordinate rules, then iterate.
    function automatic void model(input logic [DW-1:0] x0, y0, z0, input logic [1:0] c,
                                  input logic v, output logic [DW-1:0] xo, yo, zo);
        int sched[$];
        int x, y, z, d, xs, ys, dz, xn, k;
        if (c == 2'd2) begin
            k = 1;
            while (sched.size() < ITER) begin
                sched.push_back(k);
                if ((k == 4 || k == 13) && sched.size() < ITER) sched.push_back(k);
                k++;
            end
        end else begin
            for (int i = 0; i < ITER; i++) sched.push_back(i);
        end
        x = int'($signed(x0));
        y = int'($signed(y0));
        z = int'($signed(z0));
        foreach (sched[i]) begin
            d  = v ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            xs = x >>> sched[i];
            ys = y >>> sched[i];
            dz = int'($signed(tbl[c][sched[i]]));
            case (c)
                2'd1:    xn = x;
                2'd2:    xn = x + d * ys;
                default: xn = x - d * ys;
            endcase
            y = wrap16(y + d * xs);
            z = wrap16(z - d * dz);
            x = wrap16(xn);
        end
        xo = 16'(x);
        yo = 16'(y);
        zo = 16'(z);
    endfunction

    // Present an operand and wait (bounded) until it is accepted; ends #1 after acceptance.
    task automatic send(input logic [DW-1:0] x, y, z, input logic [1:0] c, input logic v);
        int n;
        in_x = x; in_y = y; in_z = z; in_coord = c; in_vec = v; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sh_q.delete(); co_q.delete();
        sh_q.push_back(int'(tbl_shift));
        co_q.push_back(int'(tbl_coord));
    endtask

    // Wait (bounded) for out_valid, recording the table address on every RUN cycle.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < ITER + 20) begin
            @(posedge clk); #1; lat++;
            if (!out_valid) begin
                sh_q.push_back(int'(tbl_shift));
                co_q.push_back(int'(tbl_coord));
            end
        end
        check_eq("latency", 32'(lat), 32'(ITER));
    endtask

    task automatic check_result(input logic [DW-1:0] x, y, z, input logic [1:0] c,
                                input logic v, input int lat);
        logic [DW-1:0] ex, ey, ez;
        model(x, y, z, c, v, ex, ey, ez);
        n_ops++;
        $display("op %0d coord=%0d vec=%0d in=(%h,%h,%h) out=(%h,%h,%h) ref=(%h,%h,%h) lat=%0d",
                 n_ops, c, v, x, y, z, out_x, out_y, out_z, ex, ey, ez, lat);
        check_eq("out_x", 32'(out_x), 32'(ex));
        check_eq("out_y", 32'(out_y), 32'(ey));
        check_eq("out_z", 32'(out_z), 32'(ez));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("released_valid", 32'(out_valid), 32'd0);
        check_eq("released_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [DW-1:0] x, y, z, input logic [1:0] c, input logic v);
        int lat;
        send(x, y, z, c, v);
        wait_done(lat);
        check_result(x, y, z, c, v, lat);
        release_result();
    endtask

    initial begin
        int lat;
        int hyp_sched[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
        logic [DW-1:0] ox, oy, oz;
        real p, v;

        p = 1.0;
        for (int i = 0; i < 32; i++) begin
            v = $atan(p) * 16384.0;
            tbl[0][i] = 16'($rtoi(v + 0.5));
            tbl[3][i] = tbl[0][i];
            tbl[1][i] = 16'(32'h4000 >> i);
            if (i == 0) tbl[2][i] = '0;
            else begin
                v = 0.5 * $ln((1.0 + p) / (1.0 - p)) * 16384.0;
                tbl[2][i] = 16'($rtoi(v + 0.5));
            end
            p = p / 2.0;
        end

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_coord = '0; in_vec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outs", {out_x, out_y}, 32'd0);
        check_eq("rst_out_z", 32'(out_z), 32'd0);
        check_eq("rst_tbl", {25'd0, tbl_coord, tbl_shift}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Circular rotation by pi/4
        send(16'h26DD, 16'h0000, 16'h3244, 2'd0, 1'b0);
        wait_done(lat);
        check_result(16'h26DD, 16'h0000, 16'h3244, 2'd0, 1'b0, lat);
        check_eq("crot_x_tol", near(out_x, 32'h2D41, 4), 32'd1);
        check_eq("crot_y_tol", near(out_y, 32'h2D41, 4), 32'd1);
        check_eq("crot_z_tol", near(out_z, 0, 4), 32'd1);
        release_result();

        // Circular vectoring
        send(16'h2000, 16'h2000, 16'h0000, 2'd0, 1'b1);
        wait_done(lat);
        check_result(16'h2000, 16'h2000, 16'h0000, 2'd0, 1'b1, lat);
        check_eq("cvec_y_tol", near(out_y, 0, 4), 32'd1);
        check_eq("cvec_z_tol", near(out_z, 32'h3244, 4), 32'd1);
        check_eq("cvec_x_tol", near(out_x, 32'h4A87, 8), 32'd1);
        release_result();

        // Linear rotation (multiply)
        send(16'h2000, 16'h0000, 16'h1000, 2'd1, 1'b0);
        wait_done(lat);
        check_result(16'h2000, 16'h0000, 16'h1000, 2'd1, 1'b0, lat);
        check_eq("lin_y_tol", near(out_y, 32'h0800, 2), 32'd1);
        check_eq("lin_x_exact", 32'(out_x), 32'h2000);
        release_result();

        // Hyperbolic shift schedule and table coordinate
        send(16'h4000, 16'h1000, 16'h0000, 2'd2, 1'b1);
        wait_done(lat);
        check_eq("hyp_sched_len", 32'(sh_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < sh_q.size(); i++) begin
            check_eq($sformatf("hyp_shift[%0d]", i), 32'(sh_q[i]), 32'(hyp_sched[i]));
            check_eq($sformatf("hyp_coord[%0d]", i), 32'(co_q[i]), 32'd2);
        end
        check_result(16'h4000, 16'h1000, 16'h0000, 2'd2, 1'b1, lat);
        release_result();

        // Backpressure with a pending operand
        send(16'h1234, 16'hF100, 16'h0800, 2'd0, 1'b0);
        wait_done(lat);
        check_result(16'h1234, 16'hF100, 16'h0800, 2'd0, 1'b0, lat);
        ox = out_x; oy = out_y; oz = out_z;
        in_x = 16'h0C00; in_y = 16'h0400; in_z = 16'h0000; in_coord = 2'd0; in_vec = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_ready", 32'(in_ready), 32'd0);
            check_eq("bp_stable", 32'((out_x == ox) && (out_y == oy) && (out_z == oz)), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        check_result(16'h0C00, 16'h0400, 16'h0000, 2'd0, 1'b1, lat);
        release_result();

        // Reset in the middle of an operation
        send(16'h26DD, 16'h0000, 16'h1000, 2'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_outs", {out_x, out_y}, 32'd0);
        check_eq("midrst_out_z", 32'(out_z), 32'd0);
        lat = 0;
        for (int i = 0; i < ITER + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check_eq("midrst_no_valid", 32'(lat), 32'd0);
        run_op(16'h1800, 16'h0600, 16'hE000, 2'd0, 1'b0);

        // Randomized operations across all modes
        for (int i = 0; i < 30; i++) begin
            run_op(16'($urandom), 16'($urandom), 16'($urandom),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
